// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shared state and pattern-mode encodings for the shift sequencer
package shift_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] MODE_ROL     = 2'd0;
  localparam logic [1:0] MODE_ROR     = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;
  localparam logic [1:0] MODE_JOHNSON = 2'd3;

  localparam int PASS_W = 8;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - control/status bundle between a sequencer client and the sequencer
interface shift_sequencer_if
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
);
  logic              start;
  logic              stop;
  logic              pause;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  period;
  logic [PASS_W-1:0] cycles;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, pause, mode, period, cycles,
    input  count, busy, done
  );

  modport slave (
    input  start, stop, pause, mode, period, cycles,
    output count, busy, done
  );

endinterface

// File: rtl/shift_sequencer_prescaler.sv
// rtl/shift_sequencer_prescaler.sv - step-interval down-counter; tick fires when it reaches zero while enabled
module shift_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_reload,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_reload;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= i_reload;
      else             r_cnt <= r_cnt - DIV_W'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - pattern sequencer: rotate/bounce/Johnson stepping with pass counting and pause/stop
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  logic [1:0]        r_state;
  logic [1:0]        r_mode;
  logic [DIV_W-1:0]  r_period;
  logic [PASS_W-1:0] r_cycles;
  logic [PASS_W-1:0] r_pass;
  logic              r_dir;
  logic [WIDTH-1:0]  r_count;
  logic              r_busy;
  logic              r_done;

  logic              w_tick;
  logic              w_start_ok;
  logic              w_pres_clr;
  logic              w_pres_en;
  logic [DIV_W-1:0]  w_reload;
  logic [WIDTH-1:0]  w_next_pat;
  logic              w_next_dir;
  logic              w_pass_end;
  logic [PASS_W-1:0] w_pass_inc;
  logic              w_seq_done;

  function automatic logic [WIDTH-1:0] f_seed(input logic [1:0] m);
    logic [WIDTH-1:0] s;
    s = '0;
    case (m)
      MODE_ROR:     s[WIDTH-1] = 1'b1;
      MODE_JOHNSON: s = '0;
      default:      s[0] = 1'b1;
    endcase
    return s;
  endfunction

  assign w_start_ok = bus.start && !bus.stop;
  assign w_pres_clr = (r_state == ST_IDLE) && w_start_ok;
  assign w_pres_en  = (r_state == ST_RUN) && !bus.stop && !bus.pause;
  assign w_reload   = (r_state == ST_IDLE) ? bus.period : r_period;

  shift_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_pres_clr),
    .i_en     (w_pres_en),
    .i_reload (w_reload),
    .o_tick   (w_tick)
  );

  // r_dir: 0 = moving toward MSB, 1 = moving toward LSB (bounce only)
  always_comb begin
    w_next_pat = r_count;
    w_next_dir = r_dir;
    case (r_mode)
      MODE_ROL: w_next_pat = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
      MODE_ROR: w_next_pat = {r_count[0], r_count[WIDTH-1:1]};
      MODE_BOUNCE: begin
        if (!r_dir) begin
          if (r_count[WIDTH-1]) begin
            w_next_pat = r_count >> 1;
            w_next_dir = 1'b1;
          end else begin
            w_next_pat = r_count << 1;
          end
        end else begin
          if (r_count[0]) begin
            w_next_pat = r_count << 1;
            w_next_dir = 1'b0;
          end else begin
            w_next_pat = r_count >> 1;
          end
        end
      end
      default: w_next_pat = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
    endcase
  end

  assign w_pass_end = (w_next_pat == f_seed(r_mode));
  assign w_pass_inc = r_pass + 8'd1;
  assign w_seq_done = w_pass_end && (r_cycles != '0) && (w_pass_inc == r_cycles);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_mode   <= MODE_ROL;
      r_period <= '0;
      r_cycles <= '0;
      r_pass   <= '0;
      r_dir    <= 1'b0;
      r_count  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state  <= ST_RUN;
            r_mode   <= bus.mode;
            r_period <= bus.period;
            r_cycles <= bus.cycles;
            r_count  <= f_seed(bus.mode);
            r_pass   <= '0;
            r_dir    <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_pass  <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (bus.pause) begin
            r_state <= ST_HOLD;
          end else if (w_tick) begin
            if (w_seq_done) begin
              r_state <= ST_DONE;
              r_count <= f_seed(r_mode);
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_count <= w_next_pat;
              r_dir   <= w_next_dir;
              if (w_pass_end) r_pass <= w_pass_inc;
            end
          end
        end
        ST_HOLD: begin
          if (bus.stop) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_pass  <= '0;
            r_dir   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (!bus.pause) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_count <= '0;
          r_pass  <= '0;
          r_dir   <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - randomized and directed bench for shift_sequencer against a step-index model
module tb_shift_sequencer;

  localparam int W  = 8;
  localparam int DW = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  shift_sequencer_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  shift_sequencer #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a sequence is a step index into the ideal pattern plus cycles left until the next step
  bit m_seq  = 1'b0;
  bit m_hold = 1'b0;
  bit m_done = 1'b0;
  int m_step = 0;
  int m_wait = 0;
  int m_mode = 0;
  int m_period = 0;
  int m_cycles = 0;

  function automatic int plen(input int md);
    case (md)
      0, 1:    return W;
      2:       return 2 * W - 2;
      default: return 2 * W;
    endcase
  endfunction

  function automatic logic [W-1:0] pat(input int md, input int k);
    logic [W-1:0] one;
    logic [W-1:0] ones;
    int p;
    one  = 1;
    ones = '1;
    case (md)
      0: return one << (k % W);
      1: return (one << (W - 1)) >> (k % W);
      2: begin
        p = k % (2 * W - 2);
        if (p >= W) p = 2 * W - 2 - p;
        return one << p;
      end
      default: begin
        p = k % (2 * W);
        if (p <= W) return ~(ones << p);
        return ones << (p - W);
      end
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_seq = 0; m_hold = 0; m_done = 0; m_step = 0; m_wait = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_seq) begin
      if (bus.start && !bus.stop) begin
        m_seq = 1; m_hold = 0; m_step = 0;
        m_mode = int'(bus.mode); m_period = int'(bus.period); m_cycles = int'(bus.cycles);
        m_wait = m_period;
      end
    end else if (bus.stop) begin
      m_seq = 0; m_hold = 0;
    end else if (m_hold) begin
      if (!bus.pause) m_hold = 0;
    end else if (bus.pause) begin
      m_hold = 1;
    end else if (m_wait == 0) begin
      m_step++;
      m_wait = m_period;
      if (m_cycles != 0 && m_step == m_cycles * plen(m_mode)) begin
        m_seq = 0; m_done = 1;
      end
    end else begin
      m_wait--;
    end
  end

  function automatic logic [W-1:0] exp_count();
    if (m_seq)  return pat(m_mode, m_step);
    if (m_done) return pat(m_mode, 0);
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("count", 32'(bus.count), 32'(exp_count()));
    chk("busy", 32'(bus.busy), 32'(m_seq));
    chk("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic go(input int md, input int per, input int cyc);
    bus.mode = md[1:0]; bus.period = per[DW-1:0]; bus.cycles = cyc[7:0];
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  logic [7:0] jlit [0:16];
  int n;
  logic [W-1:0] held;

  initial begin
    jlit = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
             8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    bus.start = 0; bus.stop = 0; bus.pause = 0;
    bus.mode = 0; bus.period = 0; bus.cycles = 0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    reset = 1'b1;
    step();

    // Rotate-left single pass at full speed
    go(0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      chk("rol_walk", 32'(bus.count), 32'(1) << i);
      step();
    end
    chk("rol_end_count", 32'(bus.count), 32'h01);
    chk("rol_end_done", 32'(bus.done), 1);
    step();
    chk("rol_idle_count", 32'(bus.count), 0);
    chk("rol_idle_busy", 32'(bus.busy), 0);

    // Bounce, two passes, 3 cycles per step
    go(2, 2, 2);
    n = 0;
    while (!bus.done && n < 300) begin
      step();
      n++;
    end
    chk("bounce_len", 32'(n), 84);
    step();
    chk("bounce_single_done", 32'(bus.done), 0);
    chk("bounce_busy_after", 32'(bus.busy), 0);

    // Johnson free-running, then stop
    go(3, 0, 0);
    for (int i = 0; i < 17; i++) begin
      chk("johnson_walk", 32'(bus.count), 32'(jlit[i]));
      step();
    end
    repeat (20) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("stop_count", 32'(bus.count), 0);
    chk("stop_done", 32'(bus.done), 0);
    chk("stop_busy", 32'(bus.busy), 0);

    // Rotate-right with a 5-cycle pause
    go(1, 3, 0);
    repeat (5) step();
    bus.pause = 1'b1;
    step();
    held = exp_count();
    repeat (5) begin
      step();
      chk("pause_count", 32'(bus.count), 32'(held));
      chk("pause_busy", 32'(bus.busy), 1);
    end
    bus.pause = 1'b0;
    repeat (20) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;

    // start while busy, then start+stop together in idle
    go(0, 1, 0);
    repeat (3) step();
    bus.mode = 2'd3; bus.period = 16'd0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (6) step();
    bus.stop = 1'b1;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("startstop_count", 32'(bus.count), 0);
    chk("startstop_busy", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a run
    go(2, 1, 0);
    repeat (6) step();
    #3 reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    step();
    step();
    reset = 1'b1;
    bus.start = 1'b0;
    step();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_count", 32'(bus.count), 0);

    // Randomized control traffic
    for (int i = 0; i < 6000; i++) begin
      bus.start = ($urandom % 10 == 0);
      bus.stop  = ($urandom % 150 == 0);
      if ($urandom % 12 == 0) bus.pause = ~bus.pause;
      bus.mode   = 2'($urandom % 4);
      bus.period = DW'($urandom % 3);
      bus.cycles = ($urandom % 4 == 0) ? 8'd0 : 8'(1 + $urandom % 2);
      step();
    end
    bus.start = 0; bus.pause = 0; bus.stop = 1;
    step();
    bus.stop = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
